// File: rtl/regfile_sb.sv
// regfile_sb: parametrised 2-read/1-write register file with byte-lane
// writes, optional write-to-read bypass and a per-register pending scoreboard.
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                WE,
  input  logic [ADDR_W-1:0]   Rw,
  input  logic [DATA_W/8-1:0] WBE,
  input  logic [DATA_W-1:0]   busW,
  input  logic [ADDR_W-1:0]   Ra,
  input  logic [ADDR_W-1:0]   Rb,
  output logic [DATA_W-1:0]   busA,
  output logic [DATA_W-1:0]   busB,
  output logic                RdyA,
  output logic                RdyB,
  input  logic                Issue,
  input  logic [ADDR_W-1:0]   Rd,
  output logic [ADDR_W:0]     PendCnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned NLANE = DATA_W / 8;
  localparam logic        BYP   = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pendNext;
  logic [ADDR_W:0]   pendCntNext;
  logic [DATA_W-1:0] laneMask;
  logic              wrEn;
  logic              bypA;
  logic              bypB;

  // Expand byte enables into a bit mask so lane merging is a plain and/or.
  for (genvar g = 0; g < NLANE; g++) begin : gLane
    assign laneMask[8*g +: 8] = {8{WBE[g]}};
  end

  assign wrEn = WE && (Rw != '0);

  // Next scoreboard state: clear on writeback first, then set on issue so set wins.
  always_comb begin
    pendNext = pend;
    if (wrEn) pendNext[Rw] = 1'b0;
    if (Issue && (Rd != '0)) pendNext[Rd] = 1'b1;
    pendNext[0] = 1'b0;
    pendCntNext = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pendCntNext = pendCntNext + {{ADDR_W{1'b0}}, pendNext[i[ADDR_W-1:0]]};
    end
  end

  // Register storage, scoreboard and pending count, all with synchronous reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i[ADDR_W-1:0]] <= '0;
      end
      pend    <= '0;
      PendCnt <= '0;
    end else begin
      if (wrEn) regs[Rw] <= (busW & laneMask) | (regs[Rw] & ~laneMask);
      pend    <= pendNext;
      PendCnt <= pendCntNext;
    end
  end

  // Read ports: register 0 reads zero; bypass is gated by reset so reads stay 0 in reset.
  always_comb begin
    bypA = BYP && Rst_n && wrEn && (Rw == Ra);
    bypB = BYP && Rst_n && wrEn && (Rw == Rb);
    busA = '0;
    busB = '0;
    if (Ra != '0) busA = bypA ? ((busW & laneMask) | (regs[Ra] & ~laneMask)) : regs[Ra];
    if (Rb != '0) busB = bypB ? ((busW & laneMask) | (regs[Rb] & ~laneMask)) : regs[Rb];
    RdyA = bypA || !pend[Ra];
    RdyB = bypB || !pend[Rb];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb (bypass, no-bypass and small builds).
module tb_regfile_sb;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Rst_n, WE, Issue;
  logic [4:0]  Rw, Ra, Rb, Rd;
  logic [3:0]  WBE;
  logic [31:0] busW;
  logic [31:0] busA, busB, nbBusA, nbBusB;
  logic        RdyA, RdyB, nbRdyA, nbRdyB;
  logic [5:0]  PendCnt, nbPendCnt;

  logic        smWE, smIssue;
  logic [2:0]  smRw, smRa, smRb, smRd;
  logic [1:0]  smWBE;
  logic [15:0] smBusW, smBusA, smBusB;
  logic        smRdyA, smRdyB;
  logic [3:0]  smPendCnt;

  regfile_sb dut (
    .Clk(Clk), .Rst_n(Rst_n), .WE(WE), .Rw(Rw), .WBE(WBE), .busW(busW),
    .Ra(Ra), .Rb(Rb), .busA(busA), .busB(busB), .RdyA(RdyA), .RdyB(RdyB),
    .Issue(Issue), .Rd(Rd), .PendCnt(PendCnt)
  );

  regfile_sb #(.BYPASS(0)) dutNb (
    .Clk(Clk), .Rst_n(Rst_n), .WE(WE), .Rw(Rw), .WBE(WBE), .busW(busW),
    .Ra(Ra), .Rb(Rb), .busA(nbBusA), .busB(nbBusB), .RdyA(nbRdyA), .RdyB(nbRdyB),
    .Issue(Issue), .Rd(Rd), .PendCnt(nbPendCnt)
  );

  regfile_sb #(.DATA_W(16), .ADDR_W(3)) dutSm (
    .Clk(Clk), .Rst_n(Rst_n), .WE(smWE), .Rw(smRw), .WBE(smWBE), .busW(smBusW),
    .Ra(smRa), .Rb(smRb), .busA(smBusA), .busB(smBusB), .RdyA(smRdyA), .RdyB(smRdyB),
    .Issue(smIssue), .Rd(smRd), .PendCnt(smPendCnt)
  );

  typedef struct {
    string       tag;
    int          id;
    logic [63:0] exp;
  } expT;

  expT sbQ[$];
  int  nChecks = 0;
  int  nErrors = 0;

  logic [31:0] mRegs [32];
  logic [31:0] mPend;
  int          mCnt;
  bit          modelValid = 1'b0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expRead(input logic [4:0] ra, input bit byp);
    logic [31:0] mask;
    mask = {{8{WBE[3]}}, {8{WBE[2]}}, {8{WBE[1]}}, {8{WBE[0]}}};
    if (ra == 5'd0) return 32'd0;
    if (byp && Rst_n && WE && (Rw == ra)) return (busW & mask) | (mRegs[ra] & ~mask);
    return mRegs[ra];
  endfunction

  function automatic logic expRdy(input logic [4:0] ra, input bit byp);
    if (byp && Rst_n && WE && (Rw == ra) && (ra != 5'd0)) return 1'b1;
    return !mPend[ra];
  endfunction

  function automatic logic [63:0] observe(input int id);
    case (id)
      0:  return 64'(busA);
      1:  return 64'(busB);
      2:  return 64'(RdyA);
      3:  return 64'(RdyB);
      4:  return 64'(PendCnt);
      5:  return 64'(nbBusA);
      6:  return 64'(nbBusB);
      7:  return 64'(nbRdyA);
      8:  return 64'(nbRdyB);
      9:  return 64'(nbPendCnt);
      10: return 64'(smBusA);
      11: return 64'(smRdyA);
      12: return 64'(smPendCnt);
      default: return 64'hx;
    endcase
  endfunction

  task automatic pushExp(input string tag, input int id, input logic [63:0] exp);
    expT e;
    e.tag = tag;
    e.id  = id;
    e.exp = exp;
    sbQ.push_back(e);
  endtask

  task automatic pushAuto();
    if (modelValid) begin
      pushExp("mBusA",   0, 64'(expRead(Ra, 1'b1)));
      pushExp("mBusB",   1, 64'(expRead(Rb, 1'b1)));
      pushExp("mRdyA",   2, 64'(expRdy(Ra, 1'b1)));
      pushExp("mRdyB",   3, 64'(expRdy(Rb, 1'b1)));
      pushExp("mCnt",    4, 64'(mCnt));
      pushExp("nbBusA",  5, 64'(expRead(Ra, 1'b0)));
      pushExp("nbBusB",  6, 64'(expRead(Rb, 1'b0)));
      pushExp("nbRdyA",  7, 64'(expRdy(Ra, 1'b0)));
      pushExp("nbRdyB",  8, 64'(expRdy(Rb, 1'b0)));
      pushExp("nbCnt",   9, 64'(mCnt));
    end
  endtask

  task automatic updateModel();
    logic [31:0] mask;
    mask = {{8{WBE[3]}}, {8{WBE[2]}}, {8{WBE[1]}}, {8{WBE[0]}}};
    if (!Rst_n) begin
      for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
      mPend      = 32'd0;
      modelValid = 1'b1;
    end else begin
      if (WE && Rw != 5'd0) begin
        mRegs[Rw] = (busW & mask) | (mRegs[Rw] & ~mask);
        mPend[Rw] = 1'b0;
      end
      if (Issue && Rd != 5'd0) mPend[Rd] = 1'b1;
    end
    mCnt = $countones(mPend);
  endtask

  // Inputs change on the falling edge; outputs are compared 2 time units later.
  task automatic tick();
    expT e;
    pushAuto();
    #2;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkVal(e.tag, observe(e.id), e.exp);
    end
    @(posedge Clk);
    updateModel();
    @(negedge Clk);
  endtask

  task automatic idle();
    WE = 1'b0; Issue = 1'b0; Rw = '0; Rd = '0; WBE = '0; busW = '0;
    smWE = 1'b0; smIssue = 1'b0; smRw = '0; smRd = '0; smWBE = '0; smBusW = '0;
  endtask

  initial begin
    Rst_n = 1'b0; Ra = '0; Rb = '0; smRa = '0; smRb = '0;
    idle();
    mPend = '0; mCnt = 0;
    tick();

    // Reset state and writes to register 0
    Rst_n = 1'b1; WE = 1'b1; Rw = 5'd0; busW = 32'hDEADBEEF; WBE = 4'hF;
    for (int r = 0; r < 32; r++) begin
      Ra = r[4:0]; Rb = 5'(31 - r);
      pushExp("zeroA", 0, 64'd0);
      pushExp("zeroB", 1, 64'd0);
      pushExp("rdyRst", 2, 64'd1);
      pushExp("cntRst", 4, 64'd0);
      tick();
    end

    // Byte lanes
    idle(); WE = 1'b1; Rw = 5'd5; busW = 32'h11223344; WBE = 4'hF; tick();
    busW = 32'hAABBCCDD; WBE = 4'b0101; tick();
    idle(); Ra = 5'd5; Rb = 5'd5;
    pushExp("lanes", 0, 64'h11BB33DD);
    pushExp("lanesNb", 5, 64'h11BB33DD);
    tick();

    // Bypass vs no bypass
    WE = 1'b1; Rw = 5'd7; busW = 32'h12345678; WBE = 4'hF; Ra = 5'd7; Rb = 5'd7;
    pushExp("bypA", 0, 64'h12345678);
    pushExp("bypB", 1, 64'h12345678);
    pushExp("bypRdy", 2, 64'd1);
    pushExp("noBypA", 5, 64'd0);
    tick();
    idle();
    pushExp("noBypAfter", 5, 64'h12345678);
    tick();

    // Scoreboard
    Issue = 1'b1; Rd = 5'd3; Ra = 5'd3; tick();
    Rd = 5'd9;
    pushExp("cnt1", 4, 64'd1);
    pushExp("pendRdyA", 2, 64'd0);
    tick();
    idle();
    pushExp("cnt2", 4, 64'd2);
    tick();
    WE = 1'b1; Rw = 5'd3; busW = 32'hCAFE0003; WBE = 4'hF;
    pushExp("wbRdyByp", 2, 64'd1);
    pushExp("wbRdyNb", 7, 64'd0);
    tick();
    idle();
    pushExp("cntWb", 4, 64'd1);
    pushExp("wbRdyNbAfter", 7, 64'd1);
    tick();

    // Simultaneous set/clear, Issue to r0, clear with WBE=0
    Issue = 1'b1; Rd = 5'd4; tick();
    WE = 1'b1; Rw = 5'd4; busW = 32'h55; WBE = 4'hF; Ra = 5'd4;
    pushExp("cntPre", 4, 64'd2);
    tick();
    idle();
    pushExp("setWinsData", 0, 64'h55);
    pushExp("setWinsRdy", 2, 64'd0);
    pushExp("setWinsCnt", 4, 64'd2);
    tick();
    Issue = 1'b1; Rd = 5'd0; tick();
    idle();
    pushExp("issueR0", 4, 64'd2);
    tick();
    WE = 1'b1; Rw = 5'd9; WBE = 4'h0; busW = 32'hFFFFFFFF; Ra = 5'd9;
    pushExp("wbe0Byp", 0, 64'd0);
    tick();
    idle();
    pushExp("wbe0Data", 0, 64'd0);
    pushExp("wbe0Rdy", 7, 64'd1);
    pushExp("wbe0Cnt", 4, 64'd1);
    tick();

    // Reset mid-operation
    Issue = 1'b1; Rd = 5'd1; tick();
    Rd = 5'd2; tick();
    Rd = 5'd31; tick();
    idle(); Rst_n = 1'b0; WE = 1'b1; Rw = 5'd1; busW = 32'h77777777; WBE = 4'hF; Ra = 5'd1;
    pushExp("rstNoByp", 0, 64'd0);
    pushExp("cntPreRst", 4, 64'd4);
    tick();
    idle(); Rst_n = 1'b1;
    for (int r = 0; r < 32; r++) begin
      Ra = r[4:0]; Rb = r[4:0];
      pushExp("rstRegs", 0, 64'd0);
      pushExp("rstRegsNb", 5, 64'd0);
      pushExp("rstRdy", 2, 64'd1);
      pushExp("rstCnt", 4, 64'd0);
      tick();
    end
    WE = 1'b1; Rw = 5'd1; busW = 32'h1; WBE = 4'hF; tick();
    idle(); Ra = 5'd1;
    pushExp("postRstWr", 0, 64'd1);
    pushExp("postRstRdy", 7, 64'd1);
    tick();

    // Small build: ADDR_W=3, DATA_W=16
    smWE = 1'b1; smRw = 3'd2; smBusW = 16'hA5C3; smWBE = 2'b11; tick();
    idle(); smRa = 3'd2;
    pushExp("smData", 10, 64'hA5C3);
    tick();
    for (int d = 1; d < 8; d++) begin
      smIssue = 1'b1; smRd = d[2:0]; tick();
    end
    smRd = 3'd0;
    pushExp("smCnt7", 12, 64'd7);
    tick();
    idle();
    pushExp("smCnt7b", 12, 64'd7);
    pushExp("smRdy", 11, 64'd0);
    tick();
    smWE = 1'b1; smRw = 3'd7; smWBE = 2'b00; tick();
    idle();
    pushExp("smCnt6", 12, 64'd6);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file for the single-cycle/pipelined CPU datapath. It generalises the 32×32 two-read/one-write file with four additions: configurable width and depth, byte-lane write enables, optional write-to-read bypass, and a per-register scoreboard. The scoreboard marks destinations of multi-cycle operations (loads, multiply) as pending until their writeback. It sits between decode (read/issue) and writeback, and feeds hazard/stall logic.

## Interface
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; depth = 2**ADDR_W registers.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports; when 0, reads return stored contents only.
- Clk  input  1  clock; all state updates on rising edge.
- Rst_n  input  1  reset, synchronous, active-low.
- WE  input  1  writeback enable.
- Rw  input  ADDR_W  writeback register address.
- WBE  input  DATA_W/8  byte-lane write enables; bit i covers busW[8i+7:8i].
- busW  input  DATA_W  writeback data.
- Ra, Rb  input  ADDR_W  read addresses.
- busA, busB  output  DATA_W  read data, combinational.
- RdyA, RdyB  output  1  1 when the addressed register is not pending, or when it is resolved this cycle by bypass.
- Issue  input  1  mark Rd as pending at the next edge.
- Rd  input  ADDR_W  destination register to mark.
- PendCnt  output  ADDR_W+1  number of pending registers, registered.

## Operation
- Storage: regs[0..2**ADDR_W-1], DATA_W each; pend[0..2**ADDR_W-1], 1 bit each.
- Register 0 is hardwired to zero:
  - writes to Rw=0 are ignored.
  - Issue with Rd=0 is ignored.
  - pend[0] is always 0.
  - busA/busB read 0 whenever Ra/Rb=0, including under bypass.
- Write: at the edge with Rst_n=1, WE=1 and Rw≠0:
  - each byte lane with WBE[i]=1 takes busW lane i; other lanes hold.
  - WE=1 with WBE=0 writes no data but still clears pend[Rw].
- Scoreboard, at the edge with Rst_n=1:
  - WE=1, Rw≠0 clears pend[Rw].
  - Issue=1, Rd≠0 sets pend[Rd].
  - If Issue and WE target the same register in the same cycle, set wins: the register ends pending, and new data is written.
- Read, per port (A shown; B identical):
  - merged = per lane, WBE[i] ? busW lane : regs[Ra] lane.
  - If BYPASS=1 and WE=1 and Rw=Ra≠0: busA=merged and RdyA=1.
  - Otherwise busA=regs[Ra] and RdyA=!pend[Ra].
  - Bypass depends only on WE/Rw/WBE/busW, never on Issue.
- PendCnt always equals the population count of pend. It is updated in the same edge as pend, so it never reads above 2**ADDR_W-1.
- Out-of-range behaviour: none; every ADDR_W value is valid.

## Timing
- Read path: zero latency, combinational from Ra/Rb, regs, pend and (with BYPASS=1) the write inputs.
- Write: visible on busA/busB without bypass one cycle after the write edge; visible the same cycle with bypass.
- Pending: Issue at edge N makes RdyA=0 for Ra=Rd from edge N onward until the clearing writeback edge.
  - With BYPASS=1, RdyA is 1 during the writeback cycle itself.
  - With BYPASS=0, RdyA becomes 1 only after the writeback edge.
- Reset: at any edge with Rst_n=0, all regs←0, all pend←0, PendCnt←0. WE and Issue are ignored that cycle.
  - From that edge: busA=busB=0 (bypass suppressed while Rst_n=0), RdyA=RdyB=1, PendCnt=0.
  - Before the first reset edge, contents are undefined.
- Reset mid-operation: pending marks are discarded; a later writeback to a formerly pending register behaves as an ordinary write.
- Simultaneous read and write of the same register: the read returns new data iff BYPASS=1; otherwise old data.

## Test plan
- Reset/zero reg, default params: hold Rst_n=0 one edge, then write 0xDEADBEEF to Rw=0 with WBE=4'hF.
  - Required: busA=0 for every Ra; PendCnt=0; RdyA=RdyB=1.
- Byte lanes: write 0x11223344 to r5 with WBE=F, then 0xAABBCCDD with WBE=4'b0101.
  - Required: read r5 → 0x11BB33DD next cycle.
- Bypass, both settings: with BYPASS=1 and r7=0x0, drive WE=1, Rw=7, busW=0x12345678, WBE=F, Ra=Rb=7 in the same cycle.
  - Required: busA=busB=0x12345678 and RdyA=1 combinationally.
  - Same stimulus with BYPASS=0: busA=0 that cycle, 0x12345678 after the edge.
- Scoreboard: Issue Rd=3, then Rd=9 on consecutive edges.
  - Required: PendCnt 1 then 2; RdyA=0 for Ra=3.
  - Writeback r3: PendCnt=1 after the edge, RdyA=1 for Ra=3 during the writeback cycle (BYPASS=1).
- Simultaneous set/clear: with r4 pending, Issue Rd=4 and WE Rw=4 busW=0x55 in the same cycle.
  - Required after the edge: r4=0x55, pend[4]=1, PendCnt unchanged.
  - Also: Issue Rd=0 leaves PendCnt unchanged.
- Reset mid-operation: mark r1, r2 and r31 pending, then assert Rst_n=0 for one edge with WE=1, Rw=1.
  - Required: all regs=0, PendCnt=0, no write occurred.
  - ADDR_W=3, DATA_W=16 build: pend all 7 regs → PendCnt=7.
